// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared types and helpers for the 4-bit adder/subtractor result
//            collector: data width, collector state encoding and a sign
//            extension helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  localparam int DATA_W = 4;

  // Width of the value returned by sext_data. Callers cast it down to their
  // accumulator width, so no accumulator may be wider than this.
  localparam int SEXT_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } coll_state_t;

  // Two's-complement sign extension of one adder/subtractor result.
  function automatic logic [SEXT_W-1:0] sext_data(input logic [DATA_W-1:0] d);
    return {{(SEXT_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_block_acc.sv
`default_nettype none
// ============================================================================
// Module   : addsub_block_acc
// Purpose  : Block accumulator: running signed sum, sample count and overflow
//            count of the current block.
// Ports    : clk, rst           clock and synchronous active-high reset
//            clear_i            zero all three registers (block consumed)
//            accept_i           add sum_i / ovf_i to the block
//            sum_i, ovf_i       incoming result and its overflow flag
//            acc_o, cnt_o,
//            ovf_cnt_o          current register values
// Revision : 1.0 - initial release
// ============================================================================
module addsub_block_acc
  import addsub_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] sum_i,
  input  logic              ovf_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  ovf_cnt_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // clear_i and accept_i are never asserted together (clear happens in HOLD,
  // accept only in ACCUM); clear still takes priority for robustness.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (clear_i) begin
      acc_d     = '0;
      cnt_d     = '0;
      ovf_cnt_d = '0;
    end else if (accept_i) begin
      acc_d     = acc_q + ACC_W'(sext_data(sum_i));
      cnt_d     = cnt_q + CNT_W'(1);
      ovf_cnt_d = ovf_cnt_q + CNT_W'(ovf_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign acc_o     = acc_q;
  assign cnt_o     = cnt_q;
  assign ovf_cnt_o = ovf_cnt_q;

endmodule
`default_nettype wire

// File: rtl/addsub_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : addsub_result_collector
// Purpose  : Collects adder/subtractor results over a valid/ready handshake,
//            accumulates BLOCK_LEN of them (or fewer on flush) and presents a
//            summary record (sum, sample count, overflow count) downstream.
// Ports    : clk, rst                      clock, synchronous active-high reset
//            in_valid/in_ready             upstream handshake
//            in_sum, in_overflow           signed result and its overflow flag
//            flush                         close a partial block early
//            out_valid/out_ready           downstream handshake
//            out_sum, out_count,
//            out_ovf_count, out_any_ovf    summary record
// Revision : 1.0 - initial release
// ============================================================================
module addsub_result_collector
  import addsub_pkg::*;
#(
  parameter int BLOCK_LEN = 8,
  parameter int ACC_W     = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_overflow,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  out_ovf_count,
  output logic              out_any_ovf
);

  // Illegal parameter sets are rejected at elaboration.
  if (BLOCK_LEN < 2 || BLOCK_LEN > 255 ||
      ACC_W < DATA_W + $clog2(BLOCK_LEN) || ACC_W > SEXT_W ||
      CNT_W < $clog2(BLOCK_LEN + 1)) begin : g_bad_params
    $error("addsub_result_collector: illegal BLOCK_LEN/ACC_W/CNT_W");
  end

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  coll_state_t      state_q, state_d;
  logic             w_accept;
  logic             w_clear;
  logic             w_close;
  logic [CNT_W-1:0] w_cnt_post;
  logic [ACC_W-1:0] w_acc;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_ovf_cnt;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  assign w_accept  = in_valid & in_ready;
  assign w_clear   = out_valid & out_ready;

  // Count as it will be after this edge; a flush closes the block only if
  // that count is nonzero, so a flush on the accepting cycle keeps the sample.
  assign w_cnt_post = w_cnt + CNT_W'(w_accept);
  assign w_close    = (w_accept && (w_cnt == C_LAST_CNT)) ||
                      (flush && (w_cnt_post != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (w_close) state_d = HOLD;
      HOLD:    if (w_clear) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  addsub_block_acc #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_block_acc (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_clear),
    .accept_i  (w_accept),
    .sum_i     (in_sum),
    .ovf_i     (in_overflow),
    .acc_o     (w_acc),
    .cnt_o     (w_cnt),
    .ovf_cnt_o (w_ovf_cnt)
  );

  // Registers are frozen in HOLD, so the record is stable until consumed.
  assign out_sum       = w_acc;
  assign out_count     = w_cnt;
  assign out_ovf_count = w_ovf_cnt;
  assign out_any_ovf   = (w_ovf_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_addsub_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_result_collector
// Purpose  : Self-checking bench for addsub_result_collector. A block-level
//            reference model (integer sums of the samples taken so far and the
//            record awaiting hand-off) predicts every cycle's outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_result_collector;

  localparam int BLOCK_LEN = 8;
  localparam int ACC_W     = 8;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_overflow;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_ovf_count;
  logic             out_any_ovf;

  always #5 clk = ~clk;

  addsub_result_collector #(
    .BLOCK_LEN (BLOCK_LEN),
    .ACC_W     (ACC_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_overflow   (in_overflow),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_count     (out_count),
    .out_ovf_count (out_ovf_count),
    .out_any_ovf   (out_any_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: samples of the open block, and the record being held.
  int m_sum, m_cnt, m_ovf;
  bit m_hold;
  int r_sum, r_cnt, r_ovf;
  int acc_total = 0;   // sum of every sample the model says was taken
  int dut_rec   = 0;   // records the DUT actually handed off
  int dut_total = 0;   // sum of out_sum over those records

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
    r_sum = 0; r_cnt = 0; r_ovf = 0;
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic cycle(input bit r, input bit v, input logic [3:0] s,
                       input bit o, input bit f, input bit rdy);
    rst = r; in_valid = v; in_sum = s; in_overflow = o; flush = f; out_ready = rdy;
    #1;
    check("in_ready", in_ready, !m_hold);
    check("out_valid", out_valid, m_hold);
    if (m_hold) begin
      check("rec_sum", $signed(out_sum), r_sum);
      check("rec_count", out_count, r_cnt);
      check("rec_ovf_count", out_ovf_count, r_ovf);
      check("rec_any_ovf", out_any_ovf, r_ovf != 0);
      if (rdy && !r) begin
        dut_rec++;
        dut_total += $signed(out_sum);
      end
    end else if (m_cnt == 0) begin
      check("idle_sum", $signed(out_sum), 0);
      check("idle_count", out_count, 0);
      check("idle_ovf_count", out_ovf_count, 0);
      check("idle_any_ovf", out_any_ovf, 0);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 0; m_sum = 0; m_cnt = 0; m_ovf = 0;
      end
    end else begin
      if (v) begin
        m_sum += $signed(s);
        m_cnt++;
        m_ovf += o;
        acc_total += $signed(s);
      end
      if (m_cnt == BLOCK_LEN || (f && m_cnt > 0)) begin
        m_hold = 1; r_sum = m_sum; r_cnt = m_cnt; r_ovf = m_ovf;
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_rec(input string tag, input int s, input int c, input int o);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, $signed(out_sum), s);
    check({tag, "_count"}, out_count, c);
    check({tag, "_ovf_count"}, out_ovf_count, o);
    check({tag, "_any_ovf"}, out_any_ovf, o != 0);
  endtask

  logic [3:0] rs;
  int d0, t0, a0, taken;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_overflow = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state (checked inside cycle against the reset model).
    cycle(1, 0, 4'd0, 0, 0, 1);
    cycle(0, 0, 4'd0, 0, 0, 1);

    // Full block of +3.
    for (int i = 0; i < 8; i++) cycle(0, 1, 4'd3, 0, 0, 0);
    expect_rec("blk_pos3", 24, 8, 0);
    cycle(0, 0, 4'd0, 0, 0, 1);

    // Full block of -8 with overflow, then 5 cycles of backpressure with
    // upstream still offering data.
    for (int i = 0; i < 8; i++) cycle(0, 1, 4'b1000, 1, 0, 0);
    expect_rec("blk_neg8", -64, 8, 8);
    for (int i = 0; i < 5; i++) begin
      rs = 4'($urandom);
      cycle(0, 1, rs, 1'($urandom), 1'($urandom), 0);
      expect_rec("hold_stable", -64, 8, 8);
      check("hold_in_ready", in_ready, 0);
    end
    cycle(0, 1, 4'd5, 0, 0, 1);
    check("release_in_ready", in_ready, 1);
    check("release_acc_clear", $signed(out_sum), 0);

    // Flushed partial block, flush on the third accept.
    cycle(0, 1, 4'd1, 0, 0, 0);
    cycle(0, 1, 4'hE, 0, 0, 0);
    cycle(0, 1, 4'd7, 1, 1, 0);
    expect_rec("flush3", 6, 3, 1);
    cycle(0, 0, 4'd0, 0, 0, 1);

    // Lone flush on an empty block does nothing.
    cycle(0, 0, 4'd0, 0, 1, 1);
    check("lone_flush", out_valid, 0);
    cycle(0, 0, 4'd0, 0, 0, 1);

    // Partial block discarded by reset, then a full block of +1.
    d0 = dut_rec;
    taken = 0;
    while (taken < 4) begin
      if ($urandom_range(1, 0) == 1) begin
        rs = 4'($urandom);
        cycle(0, 1, rs, 1'($urandom), 0, 1);
        taken++;
      end else begin
        cycle(0, 0, 4'($urandom), 0, 0, 1);
      end
    end
    cycle(1, 0, 4'd0, 0, 0, 1);
    taken = 0;
    while (taken < 8) begin
      if ($urandom_range(1, 0) == 1) begin
        cycle(0, 1, 4'd1, 0, 0, 0);
        taken++;
      end else begin
        cycle(0, 0, 4'($urandom), 0, 0, 0);
      end
    end
    expect_rec("after_rst", 8, 8, 0);
    cycle(0, 0, 4'd0, 0, 0, 1);
    check("after_rst_records", dut_rec - d0, 1);

    // Back-to-back: in_valid and out_ready held high.
    d0 = dut_rec; t0 = dut_total; a0 = acc_total;
    for (int i = 0; i < 4 * (BLOCK_LEN + 1); i++) begin
      rs = 4'($urandom);
      cycle(0, 1, rs, 1'($urandom), 0, 1);
    end
    check("b2b_records", dut_rec - d0, 4);
    check("b2b_golden_sum", dut_total - t0, acc_total - a0);

    // Random soak.
    for (int i = 0; i < 600; i++) begin
      rs = 4'($urandom);
      cycle($urandom_range(99, 0) == 0, $urandom_range(3, 0) != 0, rs,
            1'($urandom), $urandom_range(7, 0) == 0, $urandom_range(2, 0) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
